anu_mem_arbiter: RTL and testbench

// - Shares one single-port memory bus between the core's instruction fetch port and its data (load/store) port.
// - Serialises the two accesses and generates the core's stall while an access is outstanding.
// - Handles byte/half/word lane steering and misalignment checks.
// - Sits between the core (pc/instr, mem_addr/data_out/data_in/mem_access_mode) and the unified memory.

---
 rtl/anu_mem_arbiter_pkg.sv | 30 +++
 rtl/anu_mem_arbiter_lane_steer.sv | 39 +++
 rtl/anu_mem_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_anu_mem_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/anu_mem_arbiter_pkg.sv
// Shared encodings for the memory arbiter: access modes, FSM states,
// the fetch-abort instruction and the captured memory command.
package anu_mem_arbiter_pkg;

    localparam logic [1:0] MODE_NONE = 2'b00;
    localparam logic [1:0] MODE_BYTE = 2'b01;
    localparam logic [1:0] MODE_HALF = 2'b10;
    localparam logic [1:0] MODE_WORD = 2'b11;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_IF_ACC = 2'd1;
    localparam logic [1:0] ST_D_ACC  = 2'd2;
    localparam logic [1:0] ST_D_ERR  = 2'd3;

    // Returned to the core when a fetch is abandoned, so it executes a harmless addi x0,x0,0.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mem_cmd_t;

    // Memory bus is word addressed; low byte-address bits are carried by the enables.
    function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
        return byte_addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/anu_mem_arbiter_lane_steer.sv
// Lane steering for data accesses: misalignment detection, byte enables
// and store-data replication across the 32-bit memory bus.
module anu_lane_steer
    import anu_mem_arbiter_pkg::*;
(
    input  logic [1:0]  i_mode,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    output logic        o_misalign,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata
);

    // Decode mode and low address bits into enables and replicated data.
    always_comb begin
        o_misalign = 1'b0;
        o_be       = 4'b0000;
        o_wdata    = i_wdata;
        case (i_mode)
            MODE_BYTE: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
            end
            MODE_HALF: begin
                o_misalign = i_addr_lo[0];
                o_be       = 4'b0011 << {i_addr_lo[1], 1'b0};
                o_wdata    = {2{i_wdata[15:0]}};
            end
            MODE_WORD: begin
                o_misalign = |i_addr_lo;
                o_be       = 4'b1111;
            end
            default: begin
                o_be = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/anu_mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store ports.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | no access in flight; arbitrate when no response pulse is out
// ST_IF_ACC | fetch command on the bus, waiting for m_ack or timeout
// ST_D_ACC  | data command on the bus, waiting for m_ack or timeout
// ST_D_ERR  | misaligned data request; d_done/d_err pulse, no bus cycle
module anu_mem_arbiter
    import anu_mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT    = 255,
    parameter int MAX_DBURST = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_rvalid,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_mode,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        d_err,
    output logic        stall,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [3:0]  m_be,
    output logic [31:0] m_wdata,
    input  logic        m_ack,
    input  logic [31:0] m_rdata
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int BW = (MAX_DBURST > 0) ? $clog2(MAX_DBURST + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_DBURST);

    logic [1:0]    r_state;
    mem_cmd_t      r_cmd;
    logic [TW-1:0] r_tmo;
    logic [BW-1:0] r_burst;
    logic [31:0]   r_if_rdata;
    logic          r_if_rvalid;
    logic [31:0]   r_d_rdata;
    logic          r_d_done;
    logic          r_d_err;

    logic          w_misalign;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;
    logic          w_d_valid;
    logic          w_if_valid;
    logic          w_resp_busy;
    logic          w_burst_full;
    logic          w_grant_d;
    logic          w_grant_if;
    logic          w_timeout;
    logic          w_in_acc;

    anu_lane_steer u_lane_steer (
        .i_mode     (d_mode),
        .i_addr_lo  (d_addr[1:0]),
        .i_wdata    (d_wdata),
        .o_misalign (w_misalign),
        .o_be       (w_be),
        .o_wdata    (w_wdata)
    );

    // Arbitration: data wins unless it has used up its burst allowance while a
    // fetch waits. Nothing is granted while a response pulse is out, because
    // the requester has not yet had the chance to drop or change its request.
    always_comb begin
        w_d_valid    = d_req & (d_mode != MODE_NONE);
        w_if_valid   = if_req;
        w_resp_busy  = r_if_rvalid | r_d_done;
        w_burst_full = (r_burst == BURST_MAX);
        w_grant_d    = ~w_resp_busy & w_d_valid & ~(w_burst_full & w_if_valid);
        w_grant_if   = ~w_resp_busy & w_if_valid & ~w_grant_d;
        w_timeout    = (TIMEOUT != 0) && (r_tmo == TMO_LAST);
        w_in_acc     = (r_state == ST_IF_ACC) | (r_state == ST_D_ACC);
    end

    // Sequencer: grant, drive the captured command until ack or timeout, pulse the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cmd       <= '0;
            r_tmo       <= '0;
            r_burst     <= '0;
            r_if_rdata  <= '0;
            r_if_rvalid <= 1'b0;
            r_d_rdata   <= '0;
            r_d_done    <= 1'b0;
            r_d_err     <= 1'b0;
        end else begin
            r_if_rvalid <= 1'b0;
            r_d_done    <= 1'b0;
            r_d_err     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_tmo <= '0;
                    if (w_grant_d) begin
                        if (w_if_valid && !w_burst_full) begin
                            r_burst <= r_burst + 1'b1;
                        end
                        if (w_misalign) begin
                            r_state  <= ST_D_ERR;
                            r_d_done <= 1'b1;
                            r_d_err  <= 1'b1;
                        end else begin
                            r_state       <= ST_D_ACC;
                            r_cmd.we      <= d_we;
                            r_cmd.addr    <= word_addr(d_addr);
                            r_cmd.be      <= w_be;
                            r_cmd.wdata   <= w_wdata;
                        end
                    end else if (w_grant_if) begin
                        r_burst     <= '0;
                        r_state     <= ST_IF_ACC;
                        r_cmd.we    <= 1'b0;
                        r_cmd.addr  <= word_addr(if_addr);
                        r_cmd.be    <= 4'b1111;
                        r_cmd.wdata <= '0;
                    end
                end
                ST_IF_ACC: begin
                    if (m_ack) begin
                        r_if_rdata  <= m_rdata;
                        r_if_rvalid <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else if (w_timeout) begin
                        r_if_rdata  <= NOP_INSTR;
                        r_if_rvalid <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                ST_D_ACC: begin
                    if (m_ack) begin
                        r_d_rdata <= m_rdata;
                        r_d_done  <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else if (w_timeout) begin
                        r_d_done <= 1'b1;
                        r_d_err  <= 1'b1;
                        r_state  <= ST_IDLE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                ST_D_ERR: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Bus and core-side outputs come straight from state and capture registers.
    always_comb begin
        m_req     = w_in_acc;
        m_we      = r_cmd.we & w_in_acc;
        m_addr    = r_cmd.addr;
        m_be      = r_cmd.be;
        m_wdata   = r_cmd.wdata;
        if_rdata  = r_if_rdata;
        if_rvalid = r_if_rvalid;
        d_rdata   = r_d_rdata;
        d_done    = r_d_done;
        d_err     = r_d_err;
        stall     = (if_req & ~r_if_rvalid) | (d_req & ~r_d_done);
    end

endmodule

// File: tb/tb_anu_mem_arbiter.sv
// Scoreboard bench for anu_mem_arbiter: stimulus pushes expected memory
// commands and core responses; a memory model and a response monitor pop
// and compare them independently.
module tb_anu_mem_arbiter;
    import anu_mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_rvalid;
    logic        d_req;
    logic        d_we;
    logic [1:0]  d_mode;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        d_err;
    logic        stall;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [3:0]  m_be;
    logic [31:0] m_wdata;
    logic        m_ack;
    logic [31:0] m_rdata;

    always #5 clk = ~clk;

    anu_mem_arbiter #(.TIMEOUT(8), .MAX_DBURST(1)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_rvalid(if_rvalid),
        .d_req(d_req), .d_we(d_we), .d_mode(d_mode), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err), .stall(stall),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_be(m_be), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rdata(m_rdata)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
    } mem_exp_t;

    typedef struct {
        bit          is_data;
        logic [31:0] data;
        logic        err;
        bit          chk_data;
    } rsp_exp_t;

    mem_exp_t mem_q[$];
    rsp_exp_t rsp_q[$];
    int n_chk = 0;
    int n_err = 0;
    int last_len = 0;

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endfunction

    function automatic void push_mem(input logic we, input logic [31:0] addr, input logic [3:0] be,
                                     input logic [31:0] wdata, input logic [31:0] rdata, input int lat);
        mem_exp_t e;
        e.we = we; e.addr = addr; e.be = be; e.wdata = wdata; e.rdata = rdata; e.lat = lat;
        mem_q.push_back(e);
    endfunction

    function automatic void push_rsp(input bit is_data, input logic [31:0] data, input logic err, input bit chk_data);
        rsp_exp_t e;
        e.is_data = is_data; e.data = data; e.err = err; e.chk_data = chk_data;
        rsp_q.push_back(e);
    endfunction

    // Memory model: checks each command against the expected queue and acks after its latency.
    initial begin
        mem_exp_t cur;
        int mcnt;
        mcnt = 0;
        m_ack = 1'b0;
        m_rdata = '0;
        cur.we = 1'b0; cur.addr = '0; cur.be = '0; cur.wdata = '0; cur.rdata = '0; cur.lat = 1;
        forever begin
            @(negedge clk);
            m_ack = 1'b0;
            if (m_req) begin
                mcnt++;
                if (mcnt == 1) begin
                    if (mem_q.size() == 0) begin
                        n_chk++;
                        n_err++;
                        $display("FAIL unexpected_m_req: addr %0h be %0h", m_addr, m_be);
                        cur.we = m_we; cur.addr = m_addr; cur.be = m_be; cur.wdata = m_wdata;
                        cur.rdata = '0; cur.lat = 1;
                    end else begin
                        cur = mem_q.pop_front();
                        check("m_cmd", {m_we, m_addr, m_be, m_wdata}, {cur.we, cur.addr, cur.be, cur.wdata});
                    end
                end else begin
                    check("m_cmd_stable", {m_we, m_addr, m_be, m_wdata}, {cur.we, cur.addr, cur.be, cur.wdata});
                end
                if (cur.lat != 0 && mcnt == cur.lat) begin
                    m_ack = 1'b1;
                    m_rdata = cur.rdata;
                end
            end else begin
                if (mcnt != 0) last_len = mcnt;
                mcnt = 0;
            end
        end
    end

    // Response monitor: every result pulse must match the head of the response queue.
    initial begin
        rsp_exp_t e;
        forever begin
            @(negedge clk);
            if (d_done) begin
                if (rsp_q.size() == 0 || !rsp_q[0].is_data) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_d_done: d_err %0b d_rdata %0h", d_err, d_rdata);
                end else begin
                    e = rsp_q.pop_front();
                    check("d_err", d_err, e.err);
                    if (e.chk_data) check("d_rdata", d_rdata, e.data);
                end
            end
            if (if_rvalid) begin
                if (rsp_q.size() == 0 || rsp_q[0].is_data) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_if_rvalid: if_rdata %0h", if_rdata);
                end else begin
                    e = rsp_q.pop_front();
                    check("if_rdata", if_rdata, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_fetch(input logic [31:0] addr, output logic stall_first, output logic stall_pulse);
        int cyc;
        if_addr = addr;
        if_req = 1'b1;
        cyc = 0;
        stall_first = 1'b0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) stall_first = stall;
        end while (!if_rvalid && cyc < 60);
        stall_pulse = stall;
        if (!if_rvalid) begin
            n_chk++;
            n_err++;
            $display("FAIL fetch_wait: no if_rvalid after %0d cycles, required within 60", cyc);
        end
        if_req = 1'b0;
    endtask

    task automatic drive_data(input logic we, input logic [1:0] mode, input logic [31:0] addr,
                              input logic [31:0] wdata, input bit keep, output int cyc);
        d_we = we;
        d_mode = mode;
        d_addr = addr;
        d_wdata = wdata;
        d_req = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!d_done && cyc < 60);
        if (!d_done) begin
            n_chk++;
            n_err++;
            $display("FAIL data_wait: no d_done after %0d cycles, required within 60", cyc);
        end
        if (!keep) d_req = 1'b0;
    endtask

    initial begin
        logic sf, sp, sf2, sp2;
        int cyc, cyc_a;

        rst = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_mode = MODE_NONE; d_addr = '0; d_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_m_req", m_req, 1'b0);
        check("rst_if_rvalid", if_rvalid, 1'b0);
        check("rst_d_done", {d_done, d_err}, 2'b00);
        check("rst_stall", stall, 1'b0);
        check("rst_m_cmd", {m_we, m_addr, m_be, m_wdata}, 69'd0);
        rst = 1'b0;
        @(negedge clk);

        // Fetch, ack in second bus cycle.
        push_mem(1'b0, 32'h100, 4'hF, 32'h0, 32'h0050_0093, 2);
        push_rsp(1'b0, 32'h0050_0093, 1'b0, 1'b1);
        drive_fetch(32'h100, sf, sp);
        check("fetch_stall_busy", sf, 1'b1);
        check("fetch_stall_at_pulse", sp, 1'b0);
        @(negedge clk);

        // Byte store at 0x203.
        push_mem(1'b1, 32'h200, 4'b1000, 32'hABAB_ABAB, 32'h0, 1);
        push_rsp(1'b1, 32'h0, 1'b0, 1'b1);
        drive_data(1'b1, MODE_BYTE, 32'h203, 32'h0000_00AB, 1'b0, cyc);
        @(negedge clk);

        // Half store at 0x402.
        push_mem(1'b1, 32'h400, 4'b1100, 32'h1234_1234, 32'h0, 3);
        push_rsp(1'b1, 32'h0, 1'b0, 1'b1);
        drive_data(1'b1, MODE_HALF, 32'h402, 32'h0000_1234, 1'b0, cyc);
        @(negedge clk);

        // Misaligned half load: no bus cycle, error one cycle after request.
        push_rsp(1'b1, 32'h0, 1'b1, 1'b0);
        drive_data(1'b0, MODE_HALF, 32'h201, 32'h0, 1'b0, cyc);
        check("misalign_latency", cyc, 1);
        @(negedge clk);

        // Mode none: request ignored.
        d_we = 1'b0; d_mode = MODE_NONE; d_addr = 32'h600; d_req = 1'b1;
        repeat (4) @(negedge clk);
        check("mode_none_no_m_req", m_req, 1'b0);
        d_req = 1'b0;
        @(negedge clk);

        // Fetch and data together, data held across two accesses: D1, fetch (burst limit), D2.
        push_mem(1'b0, 32'h300, 4'hF, 32'h0, 32'hDEAD_BEEF, 2);
        push_mem(1'b0, 32'h104, 4'hF, 32'h0, 32'h00A0_0113, 1);
        push_mem(1'b0, 32'h304, 4'b0010, 32'h0, 32'h1122_3344, 2);
        push_rsp(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
        push_rsp(1'b0, 32'h00A0_0113, 1'b0, 1'b1);
        push_rsp(1'b1, 32'h1122_3344, 1'b0, 1'b1);
        fork
            begin
                drive_data(1'b0, MODE_WORD, 32'h300, 32'h0, 1'b1, cyc_a);
                drive_data(1'b0, MODE_BYTE, 32'h305, 32'h0, 1'b0, cyc_a);
            end
            begin
                drive_fetch(32'h104, sf2, sp2);
            end
        join
        repeat (2) @(negedge clk);
        check("order_rsp_drained", rsp_q.size(), 0);

        // Fetch timeout: m_req for 8 cycles then NOP.
        push_mem(1'b0, 32'h108, 4'hF, 32'h0, 32'h0, 0);
        push_rsp(1'b0, NOP_INSTR, 1'b0, 1'b1);
        drive_fetch(32'h108, sf, sp);
        @(negedge clk);
        check("fetch_timeout_len", last_len, 8);

        // Data timeout: d_done with d_err.
        push_mem(1'b1, 32'h500, 4'hF, 32'hCAFE_F00D, 32'h0, 0);
        push_rsp(1'b1, 32'h0, 1'b1, 1'b0);
        drive_data(1'b1, MODE_WORD, 32'h500, 32'hCAFE_F00D, 1'b0, cyc);
        @(negedge clk);
        check("data_timeout_len", last_len, 8);

        // Asynchronous reset during a data access.
        push_mem(1'b0, 32'h400, 4'hF, 32'h0, 32'h0, 0);
        d_we = 1'b0; d_mode = MODE_WORD; d_addr = 32'h400; d_wdata = 32'h0; d_req = 1'b1;
        repeat (3) @(negedge clk);
        check("m_req_before_rst", m_req, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_m_req", m_req, 1'b0);
        check("async_rst_pulses", {d_done, d_err, if_rvalid}, 3'b000);
        check("async_rst_m_be", m_be, 4'h0);
        d_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_idle_m_req", m_req, 1'b0);
        check("post_rst_stall", stall, 1'b0);

        repeat (2) @(negedge clk);
        check("mem_q_empty", mem_q.size(), 0);
        check("rsp_q_empty", rsp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
